// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: issues reads to a 1-cycle synchronous ROM and
// buffers returned words with their PCs in a small prefetch FIFO for the decoder.
module ifetch_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                ROM_AW   = 14,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       rom_req_o,
    output logic [ROM_AW-1:0]          rom_adr_o,
    input  logic [31:0]                rom_data_i,
    input  logic                       redirect_i,
    input  logic [ADDR_W-1:0]          redirect_pc_i,
    output logic                       inst_valid_o,
    input  logic                       inst_ready_i,
    output logic [31:0]                inst_o,
    output logic [ADDR_W-1:0]          inst_pc_o,
    output logic [ADDR_W-1:0]          inst_pc4_o,
    output logic [$clog2(DEPTH):0]     queue_count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic [ROM_AW-1:0] r_adr_hold;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic [31:0]       r_mem_inst [DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];

    logic [CW-1:0]     w_occupancy;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic [ROM_AW-1:0] w_fetch_adr;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic [CW-1:0]     w_count_next;

    // Credit is taken from registered state only, so inst_ready_i never reaches rom_req_o.
    assign w_occupancy   = r_count + {{(CW-1){1'b0}}, r_inflight};
    assign w_issue       = !reset && !redirect_i && (w_occupancy < CW'(DEPTH));
    assign w_push        = r_inflight && !redirect_i;
    assign w_pop         = (r_count != '0) && inst_ready_i;
    assign w_fetch_adr   = r_fetch_pc[ROM_AW+1:2];
    assign w_redirect_pc = redirect_pc_i & ~ADDR_W'(3);

    assign rom_req_o     = w_issue;
    assign rom_adr_o     = w_issue ? w_fetch_adr : r_adr_hold;
    assign inst_valid_o  = (r_count != '0);
    assign inst_o        = r_mem_inst[r_rd_ptr];
    assign inst_pc_o     = r_mem_pc[r_rd_ptr];
    assign inst_pc4_o    = inst_pc_o + ADDR_W'(4);
    assign queue_count_o = r_count;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_adr_hold    <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (redirect_i) begin
            // Flush everything, including the response still on its way back.
            r_fetch_pc <= w_redirect_pc;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + ADDR_W'(4);
                r_adr_hold    <= w_fetch_adr;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Entries are cleared on reset so the head reads as zero until the first fill.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_mem_inst[gi] <= '0;
                    r_mem_pc[gi]   <= '0;
                end else if (w_push && (r_wr_ptr == PW'(gi))) begin
                    r_mem_inst[gi] <= rom_data_i;
                    r_mem_pc[gi]   <= r_inflight_pc;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Randomised and directed bench for ifetch_prefetch against a queue-based
// model of the fetch stream (expected PCs in order, ROM word n = n).
module tb_ifetch_prefetch;
    localparam int          DEPTH    = 4;
    localparam int          ROM_AW   = 14;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              rom_req_o;
    logic [ROM_AW-1:0] rom_adr_o;
    logic [31:0]       rom_data_i = 32'h0;
    logic              redirect_i = 1'b0;
    logic [31:0]       redirect_pc_i = 32'h0;
    logic              inst_valid_o;
    logic              inst_ready_i = 1'b0;
    logic [31:0]       inst_o;
    logic [31:0]       inst_pc_o;
    logic [31:0]       inst_pc4_o;
    logic [2:0]        queue_count_o;

    ifetch_prefetch #(
        .ADDR_W  (32),
        .ROM_AW  (ROM_AW),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rom_req_o    (rom_req_o),
        .rom_adr_o    (rom_adr_o),
        .rom_data_i   (rom_data_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_pc4_o   (inst_pc4_o),
        .queue_count_o(queue_count_o)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(input logic [31:0] word_adr);
        return word_adr;
    endfunction

    // Synchronous ROM; garbage when not strobed so spurious pushes are visible.
    always @(posedge clock) begin
        rom_data_i <= rom_req_o ? rom_word({18'b0, rom_adr_o}) : 32'hDEAD_BEEF;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference model: PCs sitting in the queue, the PC of the outstanding read, next fetch PC.
    logic [31:0] q[$];
    bit          pend_v = 1'b0;
    logic [31:0] pend_pc = 32'h0;
    logic [31:0] exp_fetch = RESET_PC;

    logic [31:0] o_req, o_adr, o_valid, o_inst, o_pc, o_pc4, o_cnt;

    task automatic step(input bit rst, input bit rd, input logic [31:0] rpc, input bit rdy);
        bit exp_req;
        reset         = rst;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        inst_ready_i  = rdy;
        @(negedge clock);
        o_req   = 32'(rom_req_o);
        o_adr   = {18'b0, rom_adr_o};
        o_valid = 32'(inst_valid_o);
        o_inst  = inst_o;
        o_pc    = inst_pc_o;
        o_pc4   = inst_pc4_o;
        o_cnt   = 32'(queue_count_o);

        exp_req = !rst && !rd && ((q.size() + int'(pend_v)) < DEPTH);
        check_val("rom_req", o_req, 32'(exp_req));
        if (exp_req) check_val("rom_adr", o_adr, {18'b0, exp_fetch[15:2]});
        check_val("count", o_cnt, 32'(q.size()));
        check_val("valid", o_valid, 32'(q.size() != 0));
        if (q.size() != 0) begin
            check_val("head_pc", o_pc, q[0]);
            check_val("head_inst", o_inst, rom_word({18'b0, q[0][15:2]}));
            check_val("head_pc4", o_pc4, q[0] + 32'd4);
        end

        if (rst) begin
            q.delete();
            pend_v    = 1'b0;
            exp_fetch = RESET_PC;
        end else if (rd) begin
            q.delete();
            pend_v    = 1'b0;
            exp_fetch = rpc & ~32'd3;
        end else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (pend_v) q.push_back(pend_pc);
            pend_v = exp_req;
            if (exp_req) begin
                pend_pc   = exp_fetch;
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, o_valid, 32'd0);
        check_val({tag, "_inst"},  o_inst,  32'd0);
        check_val({tag, "_pc"},    o_pc,    32'd0);
        check_val({tag, "_pc4"},   o_pc4,   32'd4);
        check_val({tag, "_cnt"},   o_cnt,   32'd0);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check_val("rst_req", o_req, 32'd0);
        check_val("rst_adr", o_adr, 32'd0);
        check_reset_outputs("rst");

        // Streaming with the decoder always ready
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            check_val("seq_adr", o_adr, 32'(i));
            if (i == 1) check_val("c1_valid", o_valid, 32'd0);
            if (i >= 2) begin
                check_val("seq_valid", o_valid, 32'd1);
                check_val("seq_inst", o_inst, 32'(i - 2));
                check_val("seq_pc", o_pc, 32'(4 * (i - 2)));
                check_val("seq_pc4", o_pc4, 32'(4 * (i - 1)));
            end
        end

        // Stall until full, then a single pop
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check_val("stall_cnt", o_cnt, 32'd4);
        check_val("stall_req", o_req, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("pop_req", o_req, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_val("resume_req", o_req, 32'd1);
        check_val("resume_cnt", o_cnt, 32'd3);

        // Redirect with 3 queued and one in flight
        step(1'b0, 1'b1, 32'h103, 1'b0);
        check_val("redir_cnt_before", o_cnt, 32'd3);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("redir_r1_cnt", o_cnt, 32'd0);
        check_val("redir_r1_adr", o_adr, 32'h40);
        check_val("redir_r1_valid", o_valid, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("redir_r2_valid", o_valid, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("redir_r3_valid", o_valid, 32'd1);
        check_val("redir_r3_pc", o_pc, 32'h100);

        // Redirect coinciding with a handshake
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h200, 1'b1);
        check_val("redir_hs_valid", o_valid, 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("redir_hs_cnt", o_cnt, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("redir_hs_valid2", o_valid, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("redir_hs_pc", o_pc, 32'h200);

        // PC wrap
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("wrap_pc0", o_pc, 32'hFFFF_FFFC);
        check_val("wrap_pc4_0", o_pc4, 32'h0);
        check_val("wrap_inst0", o_inst, 32'h3FFF);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("wrap_pc1", o_pc, 32'h0);
        check_val("wrap_pc4_1", o_pc4, 32'h4);

        // Reset mid-stream with a full queue
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check_val("full_cnt", o_cnt, 32'd4);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_reset_outputs("midrst");
        check_val("midrst_req", o_req, 32'd1);
        check_val("midrst_adr", o_adr, {18'b0, RESET_PC[15:2]});
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("midrst_first_pc", o_pc, RESET_PC);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          r_rst, r_rd, r_rdy;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 199) == 0);
            r_rd  = ($urandom_range(0, 29) == 0);
            r_pc  = $urandom;
            r_rdy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
            step(r_rst, r_rd, r_pc, r_rdy);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
